// File: rtl/jtag_port_sync.sv
// Single-clock JTAG debug port: oversamples TCK/TMS/TDI in the clk domain, runs the
// 6-state port FSM on synchronised TCK rising edges and executes MCU debug commands.
module jtag_port_sync #(
  parameter int IR_WIDTH    = 8,
  parameter int DR_WIDTH    = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  jtagTCK,
  input  logic                  jtagTDI,
  input  logic                  jtagTMS,
  output logic                  jtagTDO,
  input  logic                  isBooted,
  input  logic                  isPaused,
  output logic [ADDR_WIDTH-1:0] sramAddr,
  output logic [DR_WIDTH-1:0]   sramWrData,
  input  logic [DR_WIDTH-1:0]   sramRdData,
  output logic                  sramWr,
  output logic                  sramEn,
  output logic                  enScanRelay,
  output logic                  enSPIRelay,
  output logic                  enPaused
);

  localparam int MASK_W = $clog2(SYNC_STAGES + 2);

  localparam logic [IR_WIDTH-1:0] CMD_SET_ADDR = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] CMD_READ     = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] CMD_WRITE    = IR_WIDTH'(3);
  localparam logic [IR_WIDTH-1:0] CMD_SCAN     = IR_WIDTH'(4);
  localparam logic [IR_WIDTH-1:0] CMD_SPI      = IR_WIDTH'(5);
  localparam logic [IR_WIDTH-1:0] CMD_PAUSE    = IR_WIDTH'(6);
  localparam logic [IR_WIDTH-1:0] CMD_RUN      = IR_WIDTH'(7);
  localparam logic [IR_WIDTH-1:0] CMD_READ_INC = IR_WIDTH'(8);
  localparam logic [IR_WIDTH-1:0] CMD_WR_INC   = IR_WIDTH'(9);

  typedef enum logic [2:0] {IDLE, ISEL, DSEL, ISHFT, DSHFT, UPDATE} jtagStateT;

  jtagStateT state, nextState;

  logic [SYNC_STAGES-1:0] tckSync, tmsSync, tdiSync;
  logic                   tckPrev;
  logic [MASK_W-1:0]      maskCnt;
  logic                   tckS, tmsS, tdiS, tckRise;

  logic [IR_WIDTH-1:0]    ir;
  logic [DR_WIDTH-1:0]    dr;
  logic [ADDR_WIDTH-1:0]  addr;
  logic                   execPending, rdPending, incPending;
  logic                   captureIr, shiftIr, shiftDr, enterUpdate, cmdAllowed;

  assign tckS = tckSync[SYNC_STAGES-1];
  assign tmsS = tmsSync[SYNC_STAGES-1];
  assign tdiS = tdiSync[SYNC_STAGES-1];

  // The mask hides the false edge seen while the chains refill after reset with TCK high
  assign tckRise = tckS & ~tckPrev & (maskCnt == '0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tckSync <= '0;
      tmsSync <= '0;
      tdiSync <= '0;
      tckPrev <= 1'b0;
      maskCnt <= MASK_W'(SYNC_STAGES + 1);
    end else begin
      tckSync <= {tckSync[SYNC_STAGES-2:0], jtagTCK};
      tmsSync <= {tmsSync[SYNC_STAGES-2:0], jtagTMS};
      tdiSync <= {tdiSync[SYNC_STAGES-2:0], jtagTDI};
      tckPrev <= tckS;
      if (maskCnt != '0) maskCnt <= maskCnt - MASK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState   = state;
    captureIr   = 1'b0;
    shiftIr     = 1'b0;
    shiftDr     = 1'b0;
    enterUpdate = 1'b0;
    if (tckRise) begin
      case (state)
        IDLE:   if (!tmsS) nextState = ISEL;
        ISEL: begin
          if (tmsS) begin
            nextState = DSEL;
          end else begin
            nextState = ISHFT;
            captureIr = 1'b1;
          end
        end
        DSEL:   nextState = tmsS ? IDLE : DSHFT;
        ISHFT: begin
          shiftIr = 1'b1;
          if (tmsS) begin
            nextState   = UPDATE;
            enterUpdate = 1'b1;
          end
        end
        DSHFT: begin
          shiftDr = 1'b1;
          if (tmsS) begin
            nextState   = UPDATE;
            enterUpdate = 1'b1;
          end
        end
        UPDATE:  nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  // An unbooted MCU ignores everything; a running one only accepts the pause request
  assign cmdAllowed = isBooted & (isPaused | (ir == CMD_PAUSE));

  assign sramAddr   = addr;
  assign sramWrData = dr;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ir          <= '0;
      dr          <= '0;
      addr        <= '0;
      jtagTDO     <= 1'b0;
      execPending <= 1'b0;
      rdPending   <= 1'b0;
      incPending  <= 1'b0;
      sramEn      <= 1'b0;
      sramWr      <= 1'b0;
      enScanRelay <= 1'b0;
      enSPIRelay  <= 1'b0;
      enPaused    <= 1'b0;
    end else begin
      execPending <= enterUpdate;
      rdPending   <= 1'b0;
      incPending  <= 1'b0;
      sramEn      <= 1'b0;
      sramWr      <= 1'b0;

      case (state)
        ISHFT:   jtagTDO <= ir[0];
        DSHFT:   jtagTDO <= dr[0];
        default: jtagTDO <= 1'b0;
      endcase

      if (captureIr)    ir <= {{(IR_WIDTH-2){1'b0}}, isPaused, isBooted};
      else if (shiftIr) ir <= {tdiS, ir[IR_WIDTH-1:1]};

      // Read data lands one clk after the strobe and takes priority over a shift
      if (rdPending)    dr <= sramRdData;
      else if (shiftDr) dr <= {tdiS, dr[DR_WIDTH-1:1]};

      if (incPending) addr <= addr + ADDR_WIDTH'(1);

      if (execPending && cmdAllowed) begin
        case (ir)
          CMD_SET_ADDR: addr <= dr[ADDR_WIDTH-1:0];
          CMD_READ: begin
            sramEn    <= 1'b1;
            rdPending <= 1'b1;
          end
          CMD_WRITE: begin
            sramEn <= 1'b1;
            sramWr <= 1'b1;
          end
          CMD_SCAN: begin
            enScanRelay <= 1'b1;
            enSPIRelay  <= 1'b0;
          end
          CMD_SPI: begin
            enSPIRelay  <= 1'b1;
            enScanRelay <= 1'b0;
          end
          CMD_PAUSE: enPaused <= 1'b1;
          CMD_RUN: begin
            enPaused    <= 1'b0;
            enScanRelay <= 1'b0;
            enSPIRelay  <= 1'b0;
          end
          CMD_READ_INC: begin
            sramEn     <= 1'b1;
            rdPending  <= 1'b1;
            incPending <= 1'b1;
          end
          CMD_WR_INC: begin
            sramEn     <= 1'b1;
            sramWr     <= 1'b1;
            incPending <= 1'b1;
          end
          default: ;
        endcase
      end

      if (!isPaused && !enPaused) begin
        enScanRelay <= 1'b0;
        enSPIRelay  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jtag_port_sync.sv
// Scoreboard bench for jtag_port_sync: JTAG tasks push expected SRAM strobes and
// output-state changes; independent monitors pop and compare as the DUT produces them.
`timescale 1ns/1ps
module tb_jtag_port_sync;

  localparam int IRW  = 8;
  localparam int DRW  = 16;
  localparam int AW   = 16;
  localparam int SS   = 2;
  localparam int HALF = 8;

  logic           clk = 1'b0;
  logic           rstn;
  logic           jtagTCK, jtagTDI, jtagTMS, jtagTDO;
  logic           isBooted, isPaused;
  logic [AW-1:0]  sramAddr;
  logic [DRW-1:0] sramWrData, sramRdData;
  logic           sramWr, sramEn, enScanRelay, enSPIRelay, enPaused;

  jtag_port_sync #(.IR_WIDTH(IRW), .DR_WIDTH(DRW), .ADDR_WIDTH(AW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rstn(rstn), .jtagTCK(jtagTCK), .jtagTDI(jtagTDI), .jtagTMS(jtagTMS),
    .jtagTDO(jtagTDO), .isBooted(isBooted), .isPaused(isPaused), .sramAddr(sramAddr),
    .sramWrData(sramWrData), .sramRdData(sramRdData), .sramWr(sramWr), .sramEn(sramEn),
    .enScanRelay(enScanRelay), .enSPIRelay(enSPIRelay), .enPaused(enPaused)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic wr; logic [AW-1:0] addr; logic [DRW-1:0] data;} sramEvT;
  typedef struct packed {logic scan; logic spi; logic paused; logic [AW-1:0] addr;} outStateT;

  int       checks = 0;
  int       errors = 0;
  sramEvT   sramQ[$];
  outStateT stateQ[$];
  logic     monOn = 1'b0;
  logic     riseWatch = 1'b0;
  int       riseCount = 0;
  outStateT lastSeen, curSeen, mLast;

  logic [IRW-1:0] mIr;
  logic [DRW-1:0] mDr;
  logic [AW-1:0]  mAddr;
  logic           mScan, mSpi, mPaused;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushStateIfChanged();
    outStateT cur;
    cur = {mScan, mSpi, mPaused, mAddr};
    if (cur != mLast) begin
      stateQ.push_back(cur);
      mLast = cur;
    end
  endtask

  task automatic modelExecute();
    if (isBooted && (isPaused || mIr == 8'h06)) begin
      case (mIr)
        8'h01: mAddr = mDr[AW-1:0];
        8'h02: begin sramQ.push_back({1'b0, mAddr, mDr}); mDr = sramRdData; end
        8'h03: sramQ.push_back({1'b1, mAddr, mDr});
        8'h04: begin mScan = 1'b1; mSpi = 1'b0; end
        8'h05: begin mSpi = 1'b1; mScan = 1'b0; end
        8'h06: mPaused = 1'b1;
        8'h07: begin mPaused = 1'b0; mScan = 1'b0; mSpi = 1'b0; end
        8'h08: begin sramQ.push_back({1'b0, mAddr, mDr}); mDr = sramRdData; mAddr = mAddr + 1'b1; end
        8'h09: begin sramQ.push_back({1'b1, mAddr, mDr}); mAddr = mAddr + 1'b1; end
        default: ;
      endcase
    end
    if (!isPaused && !mPaused) begin
      mScan = 1'b0;
      mSpi  = 1'b0;
    end
    pushStateIfChanged();
  endtask

  task automatic setPaused(input logic v);
    if (!v && !mPaused) begin
      mScan = 1'b0;
      mSpi  = 1'b0;
    end
    pushStateIfChanged();
    isPaused = v;
  endtask

  // One full TCK period; TDO is sampled just before the rising edge
  task automatic applyStimulus(input logic tms, input logic tdi, input logic doExec, output logic tdoBit);
    jtagTMS = tms;
    jtagTDI = tdi;
    repeat (HALF) @(negedge clk);
    tdoBit = jtagTDO;
    if (doExec) modelExecute();
    jtagTCK = 1'b1;
    repeat (HALF) @(negedge clk);
    jtagTCK = 1'b0;
  endtask

  task automatic jtagShiftIr(input logic [IRW-1:0] value, output logic [IRW-1:0] tdoBits);
    logic b;
    mIr = value;
    applyStimulus(1'b0, 1'b0, 1'b0, b);
    applyStimulus(1'b0, 1'b0, 1'b0, b);
    for (int i = 0; i < IRW; i++) begin
      applyStimulus(i == IRW - 1, value[i], i == IRW - 1, b);
      tdoBits[i] = b;
    end
    applyStimulus(1'b1, 1'b0, 1'b0, b);
  endtask

  task automatic jtagShiftDr(input logic [DRW-1:0] value, output logic [DRW-1:0] tdoBits);
    logic b;
    mDr = value;
    applyStimulus(1'b0, 1'b0, 1'b0, b);
    applyStimulus(1'b1, 1'b0, 1'b0, b);
    applyStimulus(1'b0, 1'b0, 1'b0, b);
    for (int i = 0; i < DRW; i++) begin
      applyStimulus(i == DRW - 1, value[i], i == DRW - 1, b);
      tdoBits[i] = b;
    end
    applyStimulus(1'b1, 1'b0, 1'b0, b);
  endtask

  always @(negedge clk) begin
    if (riseWatch && dut.tckRise === 1'b1) riseCount++;
  end

  // SRAM strobe monitor
  always @(negedge clk) begin
    if (monOn && sramEn === 1'b1) begin
      if (sramQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedSramEn: got wr=%0b addr=0x%0h data=0x%0h, expected no strobe",
                 sramWr, sramAddr, sramWrData);
      end else begin
        sramEvT e;
        e = sramQ.pop_front();
        checkOutput("sramEvent", {15'd0, sramWr, sramAddr, sramWrData}, {15'd0, e});
      end
    end
  end

  // Output-state change monitor
  always @(negedge clk) begin
    if (monOn) begin
      curSeen = {enScanRelay, enSPIRelay, enPaused, sramAddr};
      if (curSeen !== lastSeen) begin
        if (stateQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedStateChange: got 0x%0h, expected 0x%0h", curSeen, lastSeen);
        end else begin
          outStateT e;
          e = stateQ.pop_front();
          checkOutput("stateChange", 32'(curSeen), 32'(e));
        end
        lastSeen = curSeen;
      end
    end
  end

  always @(negedge clk) begin
    if (monOn) begin
      assert (!(dut.rdPending && dut.shiftDr)) else begin
        errors++;
        $display("[TB] FAIL captureShiftOverlap: got overlap 1, expected 0");
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [IRW-1:0] irBits;
    logic [DRW-1:0] drBits;

    jtagTCK = 1'b1; jtagTMS = 1'b1; jtagTDI = 1'b0;
    isBooted = 1'b0; isPaused = 1'b0; sramRdData = '0; rstn = 1'b0;
    mIr = '0; mDr = '0; mAddr = '0; mScan = 1'b0; mSpi = 1'b0; mPaused = 1'b0;
    mLast = '0; lastSeen = '0;

    repeat (5) @(negedge clk);
    rstn = 1'b1;
    riseWatch = 1'b1;
    repeat (20) @(negedge clk);
    riseWatch = 1'b0;
    checkOutput("resetTckRise", riseCount, 0);
    checkOutput("resetState", 32'(dut.state), 0);
    checkOutput("resetOutputs", {jtagTDO, sramEn, sramWr, enScanRelay, enSPIRelay, enPaused}, 0);
    checkOutput("resetAddr", sramAddr, 0);
    checkOutput("resetWrData", sramWrData, 0);
    jtagTCK = 1'b0;
    repeat (HALF) @(negedge clk);
    monOn = 1'b1;

    $display("[TB] booted and paused: address set and writes");
    isBooted = 1'b1;
    setPaused(1'b1);
    jtagShiftIr(8'h01, irBits);
    checkOutput("irCaptureTdo", irBits, 8'b0000_0011);
    jtagShiftDr(16'h1234, drBits);
    checkOutput("drShiftOutInitial", drBits, 16'h0000);
    checkOutput("addrSet", sramAddr, 16'h1234);
    jtagShiftIr(8'h03, irBits);
    jtagShiftDr(16'hBEEF, drBits);
    checkOutput("drShiftOutPrev", drBits, 16'h1234);
    checkOutput("wrDataAfterWrite", sramWrData, 16'hBEEF);

    $display("[TB] read with increment across address wrap");
    jtagShiftIr(8'h01, irBits);
    jtagShiftDr(16'hFFFF, drBits);
    checkOutput("drShiftOutBeef", drBits, 16'hBEEF);
    checkOutput("addrAllOnes", sramAddr, 16'hFFFF);
    sramRdData = 16'h5A5A;
    jtagShiftIr(8'h08, irBits);
    checkOutput("addrWrap", sramAddr, 16'h0000);
    jtagShiftDr(16'h0000, drBits);
    checkOutput("readDataTdo", drBits, 16'h5A5A);
    checkOutput("addrAfterReread", sramAddr, 16'h0001);

    $display("[TB] relay and pause control");
    jtagShiftIr(8'h04, irBits);
    checkOutput("scanRelayOn", {enScanRelay, enSPIRelay}, 2'b10);
    jtagShiftIr(8'h05, irBits);
    checkOutput("spiRelayOn", {enScanRelay, enSPIRelay}, 2'b01);
    jtagShiftIr(8'h06, irBits);
    checkOutput("pauseRequest", enPaused, 1);
    jtagShiftIr(8'h04, irBits);
    jtagShiftIr(8'h07, irBits);
    checkOutput("runClearsAll", {enScanRelay, enSPIRelay, enPaused}, 3'b000);

    $display("[TB] booted, running: only pause executes");
    setPaused(1'b0);
    jtagShiftIr(8'h03, irBits);
    checkOutput("runningIrCapture", irBits, 8'b0000_0001);
    jtagShiftIr(8'h06, irBits);
    checkOutput("runningPause", enPaused, 1);

    $display("[TB] not booted: everything is a NOP");
    isBooted = 1'b0;
    setPaused(1'b1);
    for (int c = 1; c <= 9; c++) jtagShiftIr(IRW'(c), irBits);
    checkOutput("unbootedOutputs", {enScanRelay, enSPIRelay, enPaused}, 3'b001);
    checkOutput("unbootedAddr", sramAddr, 16'h0001);

    repeat (20) @(negedge clk);
    checkOutput("sramQueueDrained", sramQ.size(), 0);
    checkOutput("stateQueueDrained", stateQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
